// File: rtl/game_sequencer.sv
// game_sequencer: brick-breaker game-flow FSM (IDLE/SERVE/PLAY/PAUSE/WIN/OVER), score and lives.
// Define GAME_PAUSE_EN to build the PAUSE state; otherwise state code 3 is illegal.
module game_sequencer #(
    parameter int         LIVES       = 3,
    parameter logic [9:0] MISS_Y      = 10'd470,
    parameter int         SERVE_TICKS = 24,
    parameter int         SCORE_MAX   = 9999
) (
    input  logic        clk_22,
    input  logic        rst,
    input  logic        start,
    input  logic        collision_trig,
    input  logic [9:0]  ball_y,
    input  logic        bricks_empty,
    output logic        run,
    output logic        load_level,
    output logic        serve,
    output logic [1:0]  lives,
    output logic [13:0] score,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_WIN   = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam int                HOLD_W     = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(SERVE_TICKS - 1);
    localparam logic [13:0]       SCORE_SAT  = 14'(SCORE_MAX);
    localparam logic [1:0]        LIVES_INIT = 2'(LIVES);

    state_t              r_state;
    logic                r_start_q;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [1:0]          r_lives;
    logic [13:0]         r_score;
    logic                r_load_level;
    logic                r_serve;

    state_t              w_state_nxt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic [1:0]          w_lives_nxt;
    logic [13:0]         w_score_nxt;
    logic                w_load_nxt;
    logic                w_serve_nxt;
    logic                w_start_edge;
    logic                w_miss;
    logic [13:0]         w_score_inc;

    assign w_start_edge = start & ~r_start_q;
    // Unsigned compare: wrapped y values above the screen also count as a miss.
    assign w_miss       = (ball_y >= MISS_Y);
    assign w_score_inc  = (r_score < SCORE_SAT) ? r_score + 14'd1 : r_score;

    always_ff @(posedge clk_22 or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_start_q    <= 1'b0;
            r_hold_cnt   <= '0;
            r_lives      <= LIVES_INIT;
            r_score      <= '0;
            r_load_level <= 1'b0;
            r_serve      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values, independent of statement order.
            r_state      <= w_state_nxt;
            r_start_q    <= start;
            r_hold_cnt   <= w_hold_nxt;
            r_lives      <= w_lives_nxt;
            r_score      <= w_score_nxt;
            r_load_level <= w_load_nxt;
            r_serve      <= w_serve_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        w_state_nxt = r_state;
        w_hold_nxt  = '0;
        w_lives_nxt = r_lives;
        w_score_nxt = r_score;
        w_load_nxt  = 1'b0;
        w_serve_nxt = 1'b0;

        case (r_state)
            S_IDLE, S_OVER: begin
                if (w_start_edge) begin
                    w_state_nxt = S_SERVE;
                    w_load_nxt  = 1'b1;
                    w_serve_nxt = 1'b1;
                    w_lives_nxt = LIVES_INIT;
                    w_score_nxt = '0;
                end
            end

            S_SERVE: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = S_PLAY;
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end

            S_PLAY: begin
                if (collision_trig) begin
                    w_score_nxt = w_score_inc;
                end
                // Win beats miss, miss beats pause.
                if (bricks_empty) begin
                    w_state_nxt = S_WIN;
                end else if (w_miss) begin
                    if (r_lives <= 2'd1) begin
                        w_lives_nxt = 2'd0;
                        w_state_nxt = S_OVER;
                    end else begin
                        w_lives_nxt = r_lives - 2'd1;
                        w_state_nxt = S_SERVE;
                        w_serve_nxt = 1'b1;
                    end
                end
`ifdef GAME_PAUSE_EN
                else if (w_start_edge) begin
                    w_state_nxt = S_PAUSE;
                end
`endif
            end

`ifdef GAME_PAUSE_EN
            S_PAUSE: begin
                if (w_start_edge) begin
                    w_state_nxt = S_PLAY;
                end
            end
`endif

            S_WIN: begin
                if (w_start_edge) begin
                    w_state_nxt = S_SERVE;
                    w_load_nxt  = 1'b1;
                    w_serve_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign run        = (r_state == S_PLAY);
    assign load_level = r_load_level;
    assign serve      = r_serve;
    assign lives      = r_lives;
    assign score      = r_score;
    assign state      = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed + random stimulus against a behavioural game model.
// Expected outputs are queued per tick and compared by an independent monitor.
module tb_game_sequencer;

    localparam int LIVES       = 3;
    localparam int MISS_Y      = 470;
    localparam int SERVE_TICKS = 24;
    localparam int SCORE_MAX   = 9999;
`ifdef GAME_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    localparam int ST_IDLE = 0, ST_SERVE = 1, ST_PLAY = 2, ST_PAUSE = 3, ST_WIN = 4, ST_OVER = 5;

    logic        clk_22 = 1'b0;
    logic        rst;
    logic        start;
    logic        collision_trig;
    logic [9:0]  ball_y;
    logic        bricks_empty;
    logic        run;
    logic        load_level;
    logic        serve;
    logic [1:0]  lives;
    logic [13:0] score;
    logic [2:0]  state;

    game_sequencer #(
        .LIVES       (LIVES),
        .MISS_Y      (10'(MISS_Y)),
        .SERVE_TICKS (SERVE_TICKS),
        .SCORE_MAX   (SCORE_MAX)
    ) dut (
        .clk_22         (clk_22),
        .rst            (rst),
        .start          (start),
        .collision_trig (collision_trig),
        .ball_y         (ball_y),
        .bricks_empty   (bricks_empty),
        .run            (run),
        .load_level     (load_level),
        .serve          (serve),
        .lives          (lives),
        .score          (score),
        .state          (state)
    );

    always #5 clk_22 = ~clk_22;

    typedef struct {
        int st;
        bit run;
        bit load;
        bit srv;
        int lives;
        int score;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Behavioural game model: plain integers, serve time as ticks remaining.
    int m_state, m_lives, m_score, m_serve_left;
    bit m_start_prev, m_load, m_serve;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = ST_IDLE; m_lives = LIVES; m_score = 0; m_serve_left = 0;
        m_start_prev = 1'b0; m_load = 1'b0; m_serve = 1'b0;
    endtask

    task automatic enter_serve(input bit with_load);
        m_state      = ST_SERVE;
        m_serve_left = SERVE_TICKS;
        m_serve      = 1'b1;
        m_load       = with_load;
    endtask

    task automatic model_step(input bit s, input bit c, input int y, input bit e);
        bit st_edge;
        st_edge      = s && !m_start_prev;
        m_start_prev = s;
        m_load       = 1'b0;
        m_serve      = 1'b0;
        case (m_state)
            ST_IDLE, ST_OVER: if (st_edge) begin
                m_lives = LIVES;
                m_score = 0;
                enter_serve(1'b1);
            end
            ST_SERVE: begin
                m_serve_left--;
                if (m_serve_left == 0) m_state = ST_PLAY;
            end
            ST_PLAY: begin
                if (c && m_score < SCORE_MAX) m_score++;
                if (e) m_state = ST_WIN;
                else if (y >= MISS_Y) begin
                    m_lives--;
                    if (m_lives == 0) m_state = ST_OVER;
                    else enter_serve(1'b0);
                end else if (PAUSE_EN && st_edge) m_state = ST_PAUSE;
            end
            ST_PAUSE: if (st_edge) m_state = ST_PLAY;
            ST_WIN: if (st_edge) enter_serve(1'b1);
            default: m_state = ST_IDLE;
        endcase
    endtask

    function automatic exp_t model_out();
        exp_t x;
        x.st    = m_state;
        x.run   = (m_state == ST_PLAY);
        x.load  = m_load;
        x.srv   = m_serve;
        x.lives = m_lives;
        x.score = m_score;
        return x;
    endfunction

    task automatic tick(input bit s, input bit c, input int y, input bit e);
        @(negedge clk_22);
        start = s; collision_trig = c; ball_y = 10'(y); bricks_empty = e;
        model_step(s, c, y, e);
        exp_q.push_back(model_out());
    endtask

    task automatic serve_wait(input bit c);
        for (int i = 0; i < SERVE_TICKS; i++) tick(1'b0, c, 100, 1'b0);
    endtask

    // Monitor: one expectation per clock edge once the driver is running.
    initial begin
        forever begin
            @(posedge clk_22);
            #1;
            if (exp_q.size() != 0) begin
                exp_t x;
                x = exp_q.pop_front();
                check("state",      int'(state),      x.st);
                check("run",        int'(run),        int'(x.run));
                check("load_level", int'(load_level), int'(x.load));
                check("serve",      int'(serve),      int'(x.srv));
                check("lives",      int'(lives),      x.lives);
                check("score",      int'(score),      x.score);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; collision_trig = 1'b0; ball_y = '0; bricks_empty = 1'b0;
        model_reset();
        @(negedge clk_22);
        @(negedge clk_22);
        check("rst_state", int'(state), ST_IDLE);
        check("rst_run",   int'(run), 0);
        check("rst_load",  int'(load_level), 0);
        check("rst_serve", int'(serve), 0);
        check("rst_lives", int'(lives), LIVES);
        check("rst_score", int'(score), 0);
        rst = 1'b0;

        // Start, serve with ignored collisions, five scoring ticks, then three misses.
        tick(1'b1, 1'b0, 100, 1'b0);
        serve_wait(1'b1);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 200, 1'b0);
        tick(1'b0, 1'b0, MISS_Y, 1'b0);
        serve_wait(1'b1);
        tick(1'b0, 1'b0, 1023, 1'b0);
        serve_wait(1'b0);
        tick(1'b0, 1'b0, MISS_Y, 1'b0);
        tick(1'b0, 1'b1, 100, 1'b0);

        // Restart from OVER, then pause/resume (or ignored start without the PAUSE build).
        tick(1'b1, 1'b0, 100, 1'b0);
        serve_wait(1'b0);
        tick(1'b0, 1'b1, 100, 1'b0);
        tick(1'b1, 1'b0, 100, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 100, 1'b0);
        tick(1'b1, 1'b0, 100, 1'b0);
        tick(1'b0, 1'b0, 100, 1'b0);

        // Score saturation, then win and miss on the same tick, then next round.
        for (int i = 0; i < SCORE_MAX + 5; i++) tick(1'b0, 1'b1, $urandom_range(0, MISS_Y - 1), 1'b0);
        tick(1'b0, 1'b1, 500, 1'b1);
        tick(1'b0, 1'b0, 100, 1'b0);
        tick(1'b1, 1'b0, 100, 1'b0);
        serve_wait(1'b0);
        tick(1'b0, 1'b0, 100, 1'b0);

        // Pause (when built) then asynchronous reset between clock edges.
        tick(1'b1, 1'b0, 100, 1'b0);
        tick(1'b0, 1'b1, 100, 1'b0);
        @(negedge clk_22);
        rst = 1'b1; start = 1'b0; collision_trig = 1'b0;
        #1;
        check("async_state", int'(state), ST_IDLE);
        check("async_score", int'(score), 0);
        check("async_lives", int'(lives), LIVES);
        check("async_run",   int'(run), 0);
        model_reset();
        exp_q.push_back(model_out());
        tick(1'b0, 1'b0, 100, 1'b0);
        rst = 1'b0;

        // Randomized play.
        for (int i = 0; i < 3000; i++) begin
            bit s, c, e;
            int y;
            s = ($urandom_range(0, 7) == 0);
            c = $urandom_range(0, 1) != 0;
            e = ($urandom_range(0, 63) == 0);
            y = ($urandom_range(0, 19) == 0) ? $urandom_range(MISS_Y, 1023) : $urandom_range(0, MISS_Y - 1);
            tick(s, c, y, e);
        end

        @(posedge clk_22);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-flow controller for the brick-breaker design, clocked on the frame tick `clk_22`. It sequences the ball/brick/board datapath:
- gates its per-tick update with `run`;
- pulses a brick-map reload and a ball re-serve;
- counts score from brick collisions;
- tracks lives and detects win/lose conditions.

It sits between the keyboard decoder (start key) and the ball controller / renderer.

## Interface
Parameters:
- LIVES, 3 — lives granted at game start (1..3).
- MISS_Y, 10'd470 — `ball_y` at or beyond this is a miss (ball below paddle).
- SERVE_TICKS, 24 — `clk_22` ticks the ball is held before play resumes (≈1 s).
- SCORE_MAX, 9999 — score saturation value.

Ports:
- clk_22  in  1  frame-tick clock (~23.8 Hz).
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  start/pause key level, already stable in `clk_22` domain; edge-detected internally.
- collision_trig  in  1  brick destroyed on this tick.
- ball_y  in  10  current ball y, unsigned.
- bricks_empty  in  1  all brick cells are zero.
- run  out  1  datapath update enable.
- load_level  out  1  one-tick pulse: reload brick map.
- serve  out  1  one-tick pulse: reset ball to serve position/direction.
- lives  out  2  remaining lives.
- score  out  14  binary score.
- state  out  3  current state, for display.

## Operation
- State encoding: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, WIN=4, OVER=5. Codes 6–7 are illegal and go to IDLE.
- `start_edge` = `start` & ~`start_q`. `start_q` is a register reset to 0.
- `run` = (state==PLAY). Decoded from the state register only (Moore).
- IDLE:
  - On `start_edge`: go to SERVE; pulse `load_level` and `serve`; `lives`←LIVES; `score`←0.
- SERVE:
  - `hold_cnt` counts 0..SERVE_TICKS-1. At SERVE_TICKS-1, go to PLAY.
  - `hold_cnt` clears on every entry to SERVE.
  - `start_edge` is ignored.
- PLAY, checks in priority order:
  1. `bricks_empty` → WIN.
  2. `ball_y` ≥ MISS_Y → miss handling:
     - if `lives`==1: `lives`←0, go to OVER;
     - else: `lives`←`lives`-1, go to SERVE, pulse `serve`.
  3. `start_edge` → PAUSE (only with macro; see Configuration).
  - WIN wins over a miss on the same tick.
  - A miss wins over pause on the same tick.
- Score:
  - `score` increments on `collision_trig` only while state==PLAY, including the tick PLAY exits to WIN/SERVE/OVER.
  - Saturates at SCORE_MAX; `collision_trig` is ignored in every other state.
- PAUSE:
  - On `start_edge`, go to PLAY. `lives` and `score` are held.
- WIN:
  - On `start_edge`: go to SERVE; pulse `load_level` and `serve`.
  - `score` and `lives` are kept (next round).
- OVER:
  - On `start_edge`: same as IDLE→SERVE (full restart: `lives`←LIVES, `score`←0).
- Arithmetic: `lives` never underflows, and 0 is only reachable in OVER. `ball_y` compare is unsigned, so wrapped values (≥MISS_Y) count as a miss.

## Timing
- Reset values:
  - state=IDLE, `run`=0, `load_level`=0, `serve`=0;
  - `lives`=LIVES, `score`=0, `hold_cnt`=0, `start_q`=0.
- All outputs are registered. State, counters and pulses update on the same `clk_22` rising edge that sees the triggering input.
- `load_level` / `serve`:
  - high for exactly one tick, the tick immediately after the deciding edge;
  - never high while `run`=1.
- Start latency: `start` rising sampled at edge N → state=SERVE and pulses high after edge N.
- Serve-to-play latency: `run` rises after SERVE_TICKS ticks in SERVE.
- Miss response: the miss edge drops `run` and updates `lives` in the same tick.
- `rst` mid-game returns all outputs to reset values immediately (asynchronous). There is no `load_level` pulse until the next start.

## Configuration
- `GAME_PAUSE_EN` defined:
  - PAUSE state is implemented;
  - `start_edge` in PLAY enters PAUSE; `start_edge` in PAUSE returns to PLAY.
- `GAME_PAUSE_EN` undefined:
  - PAUSE logic is not compiled;
  - `start_edge` in PLAY is ignored;
  - state code 3 is illegal and recovers to IDLE.

## Test plan
- Reset then `start` pulse:
  - state 0→1;
  - `load_level`=`serve`=1 for one tick;
  - `lives`=3, `score`=0;
  - `run`=1 exactly 24 ticks later.
- In PLAY, 5 ticks of `collision_trig`=1 → `score`=5. Further triggers during SERVE leave `score`=5.
- Miss sequence:
  - `ball_y`=470 in PLAY with `lives`=3 → `lives`=2, state=SERVE, `serve` pulse, `run`=0;
  - repeat twice → `lives`=0, state=OVER, no `serve` pulse.
- Same tick `bricks_empty`=1 and `ball_y`=500 → state=WIN, `lives` unchanged. Then `start` → SERVE with `load_level` pulse, `score` retained.
- Preload `score`=9998, then 3 collisions → `score`=9999.
- With `GAME_PAUSE_EN`:
  - `start` in PLAY → PAUSE, `run`=0, collisions ignored; `start` again → PLAY.
  - Without the macro: `start` in PLAY leaves state=PLAY.
  - `rst` asserted asynchronously mid-PAUSE → state=IDLE, `score`=0 before the next clock.
